// File: rtl/rv_pkg.sv
// Shared types for the RV32 decode stage: op classes, opcode constants,
// the decoded-bundle struct and immediate extraction helpers.
package rv_pkg;

  localparam int RV_XLEN = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BEQ  = 3'd4,
    OP_JAL  = 3'd5,
    OP_ILL  = 3'd6
  } op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    op_e                op;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [RV_XLEN-1:0] imm;
    logic               we;
    logic               illegal;
  } dec_t;

  // All immediates sign-extend from instr[31]
  function automatic logic [RV_XLEN-1:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/rv_id_stage_if.sv
// IF->ID fetch handshake and ID->EX decoded-bundle handshake.
// slave is the decode stage side, master is the IF/EX environment side.
interface rv_id_stage_if #(parameter int XLEN = 32);
  import rv_pkg::*;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;

  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  op_e             id_op;
  logic [4:0]      id_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [XLEN-1:0] id_imm;
  logic            id_we;
  logic            id_illegal;

  modport slave (
    input  if_valid, if_pc, if_instr, id_ready,
    output if_ready, id_valid, id_pc, id_op, id_rd, id_rs1, id_rs2,
           id_imm, id_we, id_illegal
  );

  modport master (
    output if_valid, if_pc, if_instr, id_ready,
    input  if_ready, id_valid, id_pc, id_op, id_rd, id_rs1, id_rs2,
           id_imm, id_we, id_illegal
  );

endinterface

// File: rtl/rv_instr_decode.sv
// Purely combinational RV32 subset decoder (ADD/ADDI/LW/SW/BEQ/JAL).
// Kept standalone so a disassembler or tracer can reuse it.
module rv_instr_decode
  import rv_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;

  assign opcode = instr_i[6:0];
  assign rd_f   = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1_f  = instr_i[19:15];
  assign rs2_f  = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  // Fields not used by a format are forced to zero; rd==x0 never writes
  always_comb begin
    dec_o         = '0;
    dec_o.op      = OP_ILL;
    dec_o.illegal = 1'b1;
    if (opcode == OPC_OP && funct3 == 3'b000 && funct7 == 7'b0000000) begin
      dec_o.op      = OP_ADD;
      dec_o.illegal = 1'b0;
      dec_o.rd      = rd_f;
      dec_o.rs1     = rs1_f;
      dec_o.rs2     = rs2_f;
      dec_o.we      = (rd_f != 5'd0);
    end else if ((opcode == OPC_OPIMM && funct3 == 3'b000) ||
                 (opcode == OPC_LOAD && funct3 == 3'b010)) begin
      dec_o.op      = (opcode == OPC_OPIMM) ? OP_ADDI : OP_LW;
      dec_o.illegal = 1'b0;
      dec_o.rd      = rd_f;
      dec_o.rs1     = rs1_f;
      dec_o.imm     = imm_i(instr_i);
      dec_o.we      = (rd_f != 5'd0);
    end else if (opcode == OPC_STORE && funct3 == 3'b010) begin
      dec_o.op      = OP_SW;
      dec_o.illegal = 1'b0;
      dec_o.rs1     = rs1_f;
      dec_o.rs2     = rs2_f;
      dec_o.imm     = imm_s(instr_i);
    end else if (opcode == OPC_BRANCH && funct3 == 3'b000) begin
      dec_o.op      = OP_BEQ;
      dec_o.illegal = 1'b0;
      dec_o.rs1     = rs1_f;
      dec_o.rs2     = rs2_f;
      dec_o.imm     = imm_b(instr_i);
    end else if (opcode == OPC_JAL) begin
      dec_o.op      = OP_JAL;
      dec_o.illegal = 1'b0;
      dec_o.rd      = rd_f;
      dec_o.imm     = imm_j(instr_i);
      dec_o.we      = (rd_f != 5'd0);
    end
  end

endmodule

// File: rtl/rv_id_stage.sv
// RV32 decode stage: decodes IF beats and holds them in a 2-entry FIFO toward EX.
// Optional RV_ID_PERF_CNT_EN adds emitted/illegal bundle counters.
module rv_id_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  rv_id_stage_if.slave     bus
`ifdef RV_ID_PERF_CNT_EN
  ,
  output logic [31:0]      perf_decoded,
  output logic [31:0]      perf_illegal
`endif
);

  dec_t            dec_in;
  logic [XLEN-1:0] pc_q  [DEPTH];
  dec_t            dec_q [DEPTH];
  logic [1:0]      count_q, count_d;
  logic            head_q, head_d;
  logic            tail;
  logic            accept;
  logic            emit;
  logic            push;

  rv_instr_decode u_decode (
    .instr_i (bus.if_instr),
    .dec_o   (dec_in)
  );

  assign bus.if_ready = (count_q != 2'd2);
  assign bus.id_valid = (count_q != 2'd0);
  assign accept       = bus.if_valid && bus.if_ready;
  assign emit         = bus.id_valid && bus.id_ready;
  assign push         = accept && !flush;
  assign tail         = head_q ^ count_q[0];

  // Flush drops everything still buffered, but an emit in the same cycle has
  // already been sampled by EX so the head still advances.
  always_comb begin
    head_d  = head_q ^ emit;
    count_d = count_q + {1'b0, accept} - {1'b0, emit};
    if (flush) begin
      count_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]  <= bus.if_pc;
      dec_q[tail] <= dec_in;
    end
  end

  // Outputs are forced to zero while the buffer is empty
  always_comb begin
    bus.id_pc      = '0;
    bus.id_op      = OP_ADD;
    bus.id_rd      = '0;
    bus.id_rs1     = '0;
    bus.id_rs2     = '0;
    bus.id_imm     = '0;
    bus.id_we      = 1'b0;
    bus.id_illegal = 1'b0;
    if (bus.id_valid) begin
      bus.id_pc      = pc_q[head_q];
      bus.id_op      = dec_q[head_q].op;
      bus.id_rd      = dec_q[head_q].rd;
      bus.id_rs1     = dec_q[head_q].rs1;
      bus.id_rs2     = dec_q[head_q].rs2;
      bus.id_imm     = dec_q[head_q].imm;
      bus.id_we      = dec_q[head_q].we;
      bus.id_illegal = dec_q[head_q].illegal;
    end
  end

`ifdef RV_ID_PERF_CNT_EN
  logic [31:0] perf_dec_q;
  logic [31:0] perf_ill_q;

  // Counters survive flush; only reset clears them
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_dec_q <= '0;
      perf_ill_q <= '0;
    end else if (emit) begin
      perf_dec_q <= perf_dec_q + 32'd1;
      if (bus.id_illegal) begin
        perf_ill_q <= perf_ill_q + 32'd1;
      end
    end
  end

  assign perf_decoded = perf_dec_q;
  assign perf_illegal = perf_ill_q;
`endif

endmodule

// File: tb/tb_rv_id_stage.sv
// Scoreboard bench for rv_id_stage: directed test-plan beats, then random traffic
// checked against an arithmetic reference decoder. Honors RV_ID_PERF_CNT_EN.
module tb_rv_id_stage;
  import rv_pkg::*;

  typedef struct {
    logic [31:0] pc;
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic        ill;
  } exp_t;

  logic clk;
  logic reset;
  logic flush;
  int   checkCount = 0;
  int   passCount  = 0;
  bit   started    = 0;
  exp_t sb[$];
  int unsigned perfDecModel = 0;
  int unsigned perfIllModel = 0;

  rv_id_stage_if #(.XLEN(32)) bus ();

`ifdef RV_ID_PERF_CNT_EN
  logic [31:0] perf_decoded;
  logic [31:0] perf_illegal;
`endif

  rv_id_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef RV_ID_PERF_CNT_EN
    ,
    .perf_decoded (perf_decoded),
    .perf_illegal (perf_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int signExt(input int unsigned v, input int unsigned bits);
    int unsigned half = 32'd1 << (bits - 1);
    if (v >= half) return int'(v) - int'(half * 2);
    return int'(v);
  endfunction

  // Reference decoder built from field arithmetic rather than bit concatenation
  function automatic exp_t refModel(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    int unsigned w, opc, f3, f7, rdf, r1, r2;
    bit writes;
    w = ins;
    opc = w % 128; rdf = (w / 128) % 32; f3 = (w / 4096) % 8;
    r1 = (w / 32768) % 32; r2 = (w / 1048576) % 32; f7 = w / 33554432;
    e.pc = pc; e.op = OP_ILL; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0; e.we = 0; e.ill = 1;
    writes = 0;
    if (opc == 51 && f3 == 0 && f7 == 0) begin
      e.op = OP_ADD; e.rd = 5'(rdf); e.rs1 = 5'(r1); e.rs2 = 5'(r2); writes = 1;
    end else if ((opc == 19 && f3 == 0) || (opc == 3 && f3 == 2)) begin
      e.op = (opc == 19) ? OP_ADDI : OP_LW;
      e.rd = 5'(rdf); e.rs1 = 5'(r1); writes = 1;
      e.imm = 32'(signExt(w / 1048576, 12));
    end else if (opc == 35 && f3 == 2) begin
      e.op = OP_SW; e.rs1 = 5'(r1); e.rs2 = 5'(r2);
      e.imm = 32'(signExt(f7 * 32 + rdf, 12));
    end else if (opc == 99 && f3 == 0) begin
      e.op = OP_BEQ; e.rs1 = 5'(r1); e.rs2 = 5'(r2);
      e.imm = 32'(signExt((f7 / 64) * 4096 + (rdf % 2) * 2048 + (f7 % 64) * 32 + (rdf / 2) * 2, 13));
    end else if (opc == 111) begin
      e.op = OP_JAL; e.rd = 5'(rdf); writes = 1;
      e.imm = 32'(signExt((w / 32'h8000_0000) * 1048576 + ((w / 4096) % 256) * 4096 +
                          ((w / 1048576) % 2) * 2048 + ((w / 2097152) % 1024) * 2, 21));
    end
    if (e.op != OP_ILL) e.ill = 0;
    e.we = writes && (rdf != 0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drives one cycle of inputs starting just after a rising edge
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                               input logic rdy, input logic fl, input logic rstn, output logic acc);
    bus.if_valid = v; bus.if_pc = pc; bus.if_instr = ins;
    bus.id_ready = rdy; flush = fl; reset = rstn;
    @(negedge clk);
    acc = v && bus.if_ready && !fl && rstn;
    @(posedge clk);
    #1;
  endtask

  task automatic expectHead(input string tag, input op_e op, input int rd, input int rs1,
                            input int rs2, input int imm, input logic we, input logic ill);
    #1;
    checkOutput({tag, "_valid"}, 32'(bus.id_valid), 32'd1);
    checkOutput({tag, "_op"}, 32'(bus.id_op), 32'(op));
    checkOutput({tag, "_rd"}, 32'(bus.id_rd), 32'(rd));
    checkOutput({tag, "_rs1"}, 32'(bus.id_rs1), 32'(rs1));
    checkOutput({tag, "_rs2"}, 32'(bus.id_rs2), 32'(rs2));
    checkOutput({tag, "_imm"}, bus.id_imm, 32'(imm));
    checkOutput({tag, "_we"}, 32'(bus.id_we), 32'(we));
    checkOutput({tag, "_illegal"}, 32'(bus.id_illegal), 32'(ill));
  endtask

  // Predictor: updates the expected FIFO contents at each rising edge
  always @(posedge clk) begin
    if (!reset) begin
      sb.delete();
      perfDecModel = 0;
      perfIllModel = 0;
    end else if (flush) begin
      sb.delete();
    end else if (bus.if_valid && bus.if_ready) begin
      sb.push_back(refModel(bus.if_pc, bus.if_instr));
    end
  end

  // Monitor: compares the presented head against the scoreboard mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      checkOutput("id_valid", 32'(bus.id_valid), 32'(sb.size() != 0));
      checkOutput("if_ready", 32'(bus.if_ready), 32'(sb.size() < 2));
      if (bus.id_valid && sb.size() != 0) begin
        e = sb[0];
        checkOutput("sb_pc", bus.id_pc, e.pc);
        checkOutput("sb_op", 32'(bus.id_op), 32'(e.op));
        checkOutput("sb_rd", 32'(bus.id_rd), 32'(e.rd));
        checkOutput("sb_rs1", 32'(bus.id_rs1), 32'(e.rs1));
        checkOutput("sb_rs2", 32'(bus.id_rs2), 32'(e.rs2));
        checkOutput("sb_imm", bus.id_imm, e.imm);
        checkOutput("sb_we", 32'(bus.id_we), 32'(e.we));
        checkOutput("sb_illegal", 32'(bus.id_illegal), 32'(e.ill));
        if (bus.id_ready) begin
          void'(sb.pop_front());
          perfDecModel++;
          if (e.ill) perfIllModel++;
        end
      end
    end
  end

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = 7'b0; end
      1: begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
      2: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
      3: begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
      4: begin w[6:0] = 7'b1100011; w[14:12] = 3'b000; end
      5: begin w[6:0] = 7'b1101111; end
      6: begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[30] = 1'b1; end
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  typedef struct {
    logic [31:0] ins;
    op_e op;
    int rd, rs1, rs2, imm;
    logic we;
  } sweep_t;

  initial begin
    logic acc;
    logic pending;
    logic [31:0] pc, ins;
    logic v, rdy, fl;
    sweep_t sweep[5];
    sweep[0] = '{32'h002081B3, OP_ADD, 3, 1, 2, 0, 1'b1};
    sweep[1] = '{32'h00302023, OP_SW, 0, 0, 3, 0, 1'b0};
    sweep[2] = '{32'h00002203, OP_LW, 4, 0, 0, 0, 1'b1};
    sweep[3] = '{32'h00320463, OP_BEQ, 0, 4, 3, 8, 1'b0};
    sweep[4] = '{32'h010003EF, OP_JAL, 7, 0, 0, 16, 1'b1};

    reset = 1'b0; flush = 1'b0;
    bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = '0; bus.id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    started = 1;
    checkOutput("rst_id_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("rst_if_ready", 32'(bus.if_ready), 32'd1);
    checkOutput("rst_id_pc", bus.id_pc, 32'd0);
    checkOutput("rst_id_imm", bus.id_imm, 32'd0);
    checkOutput("rst_id_op", 32'(bus.id_op), 32'd0);

    applyStimulus(1, 32'h100, 32'h00500093, 1, 0, 1, acc);
    checkOutput("addi_acc", 32'(acc), 32'd1);
    expectHead("addi", OP_ADDI, 1, 0, 0, 5, 1'b1, 1'b0);

    pc = 32'h200;
    foreach (sweep[i]) begin
      applyStimulus(1, pc, sweep[i].ins, 1, 0, 1, acc);
      expectHead($sformatf("sweep%0d", i), sweep[i].op, sweep[i].rd, sweep[i].rs1,
                 sweep[i].rs2, sweep[i].imm, sweep[i].we, 1'b0);
      pc += 4;
    end
    repeat (2) applyStimulus(0, 0, 0, 1, 0, 1, acc);

    applyStimulus(1, 32'h300, 32'h002081B3, 0, 0, 1, acc);
    checkOutput("bp_acc0", 32'(acc), 32'd1);
    applyStimulus(1, 32'h304, 32'h00500093, 0, 0, 1, acc);
    checkOutput("bp_acc1", 32'(acc), 32'd1);
    applyStimulus(1, 32'h308, 32'h00302023, 0, 0, 1, acc);
    checkOutput("bp_acc2", 32'(acc), 32'd0);
    checkOutput("bp_if_ready", 32'(bus.if_ready), 32'd0);
    repeat (3) applyStimulus(0, 0, 0, 1, 0, 1, acc);

    applyStimulus(1, 32'h400, 32'h00500093, 0, 0, 1, acc);
    applyStimulus(1, 32'h404, 32'h002081B3, 0, 0, 1, acc);
    applyStimulus(1, 32'h408, 32'h010003EF, 0, 1, 1, acc);
    checkOutput("flush_id_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("flush_if_ready", 32'(bus.if_ready), 32'd1);
    repeat (2) applyStimulus(0, 0, 0, 1, 0, 1, acc);

    applyStimulus(1, 32'h500, 32'h00500093, 0, 0, 1, acc);
    applyStimulus(1, 32'h504, 32'hFFFFFFFF, 0, 0, 1, acc);
    applyStimulus(0, 0, 0, 1, 0, 1, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, acc);
    checkOutput("rst2_id_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("rst2_if_ready", 32'(bus.if_ready), 32'd1);
    checkOutput("rst2_id_pc", bus.id_pc, 32'd0);
`ifdef RV_ID_PERF_CNT_EN
    checkOutput("rst2_perf_decoded", perf_decoded, 32'd0);
    checkOutput("rst2_perf_illegal", perf_illegal, 32'd0);
`endif

    applyStimulus(1, 32'h600, 32'hFFFFFFFF, 1, 0, 1, acc);
    expectHead("illegal", OP_ILL, 0, 0, 0, 0, 1'b0, 1'b1);
    applyStimulus(1, 32'h604, 32'h00000013, 1, 0, 1, acc);
    expectHead("nop", OP_ADDI, 0, 0, 0, 0, 1'b0, 1'b0);
`ifdef RV_ID_PERF_CNT_EN
    applyStimulus(0, 0, 0, 1, 0, 1, acc);
    checkOutput("perf_illegal_one", perf_illegal, 32'd1);
`endif

    pending = 0; pc = 32'h1000; ins = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pending) ins = randInstr();
      v   = pending || ($urandom_range(0, 4) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      applyStimulus(v, pc, ins, rdy, fl, 1, acc);
      if (acc) pc += 4;
      pending = v && !acc && !fl;
    end

    repeat (4) applyStimulus(0, 0, 0, 1, 0, 1, acc);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
`ifdef RV_ID_PERF_CNT_EN
    checkOutput("perf_decoded", perf_decoded, perfDecModel);
    checkOutput("perf_illegal", perf_illegal, perfIllModel);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
